filt_scan: RTL and testbench
============================

# filt_scan

Time-multiplexed glitch-filter controller for a bank of slow asynchronous-ish level inputs such as buttons, straps and status pins. A single scan pointer visits one channel per enabled cycle, updates that channel's hysteresis counter and filtered level, and schedules level-change events onto one valid/ready output. Placed between raw input synchronisers and the interrupt/status logic, it replaces N_CH separate hysteresis filter FSMs with one shared update path.

## Interface
- N_CH, 8: number of channels; must be at least 2; pointer width PW = $clog2(N_CH).
- CNT_W, 3: width of per-channel counter and of `len`.
- DEF_LEN, 3: filter length loaded into the shadow length register at reset.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  scan enable; when 0, pointer and channel state hold.
- len  input  CNT_W  requested filter length: consecutive differing samples needed to flip.
- i  input  N_CH  raw levels, already synchronised to clk.
- y  output  N_CH  filtered levels, registered.
- ptr  output  PW  channel visited this cycle.
- frame_done  output  1  one-cycle pulse after the visit of channel N_CH-1.
- evt_valid  output  1  event available (FILT_SCAN_EVT_EN only).
- evt_ready  input  1  consumer accepts event (FILT_SCAN_EVT_EN only).
- evt_ch  output  PW  channel of the held event (FILT_SCAN_EVT_EN only).
- evt_level  output  1  new level of that channel (FILT_SCAN_EVT_EN only).

## Operation
- Reset values: y=0, every cnt=0, ptr=0, len_q=DEF_LEN, frame_done=0, pend=0, evt_valid=0, evt_ch=0, evt_level=0.
- Visit rule, when en=1 and the visited channel is c=ptr:
  - If i[c]==y[c], then cnt[c] is set to 0.
  - Else if cnt[c] >= L-1, then y[c] is inverted, cnt[c] is set to 0, and pend[c] is set to 1.
  - Otherwise cnt[c] is incremented by 1.
- L is the effective length: L = len_q, except that len_q==0 is treated as L=1 (no filtering).
- Pointer: increments by 1 per enabled cycle; wraps from N_CH-1 to 0. On that wrap edge, frame_done=1 for one cycle and len_q is loaded from `len`.
- A change of `len` mid-frame has no effect until the next frame.
- en=0: ptr, cnt, y and len_q hold. frame_done is 0. The event path keeps running.
- Event scheduling (hold register, fixed priority):
  - When the hold register is empty and pend is nonzero, it loads the lowest-index pending channel c.
  - On that load, evt_ch=c, evt_level=y[c] and pend[c] is cleared.
  - evt_valid, evt_ch and evt_level stay stable until accepted (evt_valid & evt_ready).
  - The accept edge empties the register. The next load happens at the following edge, so there is one bubble cycle between events.
- Simultaneous events: a flip on a channel whose pend is already 1 coalesces, leaving one event. A flip on the channel currently held sets pend again, which produces a second event later.
- rst_n=0 at any edge, including mid-frame or with events pending, returns all state to reset values. Pending events are discarded.

## Timing
- i[c] is sampled at the edge ending the visit cycle; y[c], cnt[c] and pend[c] update at that same edge.
- Filter latency for a step on channel c: y[c] flips at the edge ending the L-th consecutive differing visit, which is at most L*N_CH enabled cycles after the step.
- Event latency: evt_valid rises one edge after pend is set, provided the hold register is empty.
- frame_done is registered; it is high in the cycle after ptr==N_CH-1 was visited.

## Configuration
- FILT_SCAN_EVT_EN defined: pend vector, hold register and the evt_valid, evt_ready, evt_ch and evt_level ports are present.
- FILT_SCAN_EVT_EN undefined: those ports and that logic are absent. Filtering, ptr and frame_done behave identically.

## Structure
- Package filt_scan_pkg holds the DEF_LEN default constant.
- It also holds typedef filt_ch_t: a per-channel state struct with fields `level` (1 bit) and `cnt` (CNT_W bits).
- It also holds the event struct typedef filt_evt_t with fields ch and level.
- Sub-module filt_scan_evt_arb contains the lowest-index pend picker and the hold register. It is instantiated only under FILT_SCAN_EVT_EN.

## Test plan
- Step filter: N_CH=4, len=3, en=1 from reset, i[2] steps to 1 at cycle 0.
  - Required: ch2 is visited at cycles 2, 6 and 10.
  - Required: y[2] becomes 1 after the cycle-10 edge; evt_valid=1 with evt_ch=2 and evt_level=1 one edge later.
- Glitch reject: i[1]=1 for exactly 2 visits, then 0.
  - Required: y[1] stays 0 throughout; cnt[1] returns to 0; no event is produced.
- Event backpressure: ch0 and ch3 flip to 1 in the same frame while evt_ready=0.
  - Required: evt_ch=0 is held stable.
  - Required: with evt_ready=1, ch0 is accepted, then one bubble cycle, then evt_ch=3 is accepted.
- Length boundaries:
  - len changed from 3 to 1 while ptr=1: the old length still applies until frame_done; after that, a flip occurs on the first differing visit.
  - len=0: behaves as L=1.
- Enable and reset mid-operation:
  - en=0 for 5 cycles: ptr and y are frozen; a pending event is still accepted.
  - rst_n=0 while ptr=2 with pend nonzero: the next edge yields ptr=0, y=0, evt_valid=0 and len_q=3.

Source files
------------

// File: rtl/filt_scan_pkg.sv
// Shared types and defaults for the time-multiplexed glitch filter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default channel count, counter width and filter length; the
// per-channel state struct filt_ch_t and the held-event struct filt_evt_t.
package filt_scan_pkg;

    localparam int FILT_N_CH    = 8;
    localparam int FILT_PW      = $clog2(FILT_N_CH);
    localparam int FILT_CNT_W   = 3;
    localparam int FILT_DEF_LEN = 3;

    // Per-channel filter state: current filtered level and run counter of
    // consecutive visits on which the raw input disagreed with it.
    typedef struct packed {
        logic                  level;
        logic [FILT_CNT_W-1:0] cnt;
    } filt_ch_t;

    // One level-change event as presented to the consumer.
    typedef struct packed {
        logic [FILT_PW-1:0] ch;
        logic               level;
    } filt_evt_t;

endpackage

// File: rtl/filt_scan_evt_arb.sv
// Pending-event collector, lowest-index picker and single-entry hold register.
// Latency: a pend bit set at edge E is presented at edge E+1 when the hold register is empty.
// Backpressure: held event is stable until evt_valid_o & evt_ready_i; one bubble cycle follows each accept.
// Ports: clk/rst_n (sync, active-low); set_pend_i marks channels that just flipped;
// level_i is the filtered level vector sampled on load; evt_* is the valid/ready event output.
// Instantiated by filt_scan only when FILT_SCAN_EVT_EN is defined.
module filt_scan_evt_arb
    import filt_scan_pkg::*;
#(
    parameter int N_CH = FILT_N_CH,
    localparam int PW  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] set_pend_i,
    input  logic [N_CH-1:0] level_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [PW-1:0]   evt_ch_o,
    output logic            evt_level_o
);

    logic [N_CH-1:0] pend_q, pend_d, clr;
    logic            vld_q;
    filt_evt_t       hold_q, pick;
    logic            found, load;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        // Scan downward so the lowest pending index is the last one written.
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                found      = 1'b1;
                pick.ch    = PW'(k);
                pick.level = level_i[k];
            end
        end
        // Loads only from the empty state, so an accept edge never reloads:
        // that gives the single bubble cycle between back-to-back events.
        load   = !vld_q && found;
        clr    = load ? ({{(N_CH-1){1'b0}}, 1'b1} << pick.ch) : '0;
        // A flip landing on the channel being loaded re-arms it (set wins).
        pend_d = (pend_q & ~clr) | set_pend_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            vld_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (load) begin
                vld_q  <= 1'b1;
                hold_q <= pick;
            end else if (vld_q && evt_ready_i) begin
                vld_q  <= 1'b0;
            end
        end
    end

    assign evt_valid_o = vld_q;
    assign evt_ch_o    = hold_q.ch;
    assign evt_level_o = hold_q.level;

endmodule

// File: rtl/filt_scan.sv
// Shared-path hysteresis filter for N_CH slow level inputs, one channel visited per enabled cycle.
// Latency: y[c] updates at the edge ending its visit; flips after L consecutive differing visits (<= L*N_CH cycles).
// Backpressure: filtering never stalls; events queue as pend bits while evt_ready is low (FILT_SCAN_EVT_EN).
// Ports: clk, rst_n (sync, active-low), en (scan enable), len (filter length, taken at frame wrap),
// i (raw synchronised levels), y (filtered levels), ptr (channel visited this cycle),
// frame_done (pulse after channel N_CH-1 visit); evt_valid/evt_ready/evt_ch/evt_level
// exist only when the FILT_SCAN_EVT_EN macro is defined.
// CNT_W and N_CH must match the package constants that size filt_ch_t / filt_evt_t.
module filt_scan
    import filt_scan_pkg::*;
#(
    parameter int N_CH    = FILT_N_CH,
    parameter int CNT_W   = FILT_CNT_W,
    parameter int DEF_LEN = FILT_DEF_LEN,
    localparam int PW     = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] len,
    input  logic [N_CH-1:0]  i,
    output logic [N_CH-1:0]  y,
    output logic [PW-1:0]    ptr,
    output logic             frame_done
`ifdef FILT_SCAN_EVT_EN
    ,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [PW-1:0]    evt_ch,
    output logic             evt_level
`endif
);

    filt_ch_t [N_CH-1:0] ch_q;
    logic     [PW-1:0]   ptr_q;
    logic     [CNT_W-1:0] len_q;
    logic                frame_done_q;

    filt_ch_t            cur, nxt;
    logic     [CNT_W-1:0] lim;
    logic                last;

    assign last = (ptr_q == PW'(N_CH - 1));

    // Update path for the single channel under the pointer.
    always_comb begin
        cur = ch_q[ptr_q];
        nxt = cur;
        // len_q==0 behaves as length 1, so the threshold is 0 in both cases.
        lim = (len_q == '0) ? '0 : len_q - 1'b1;
        if (i[ptr_q] == cur.level) begin
            nxt.cnt = '0;
        end else if (cur.cnt >= lim) begin
            nxt.level = ~cur.level;
            nxt.cnt   = '0;
        end else begin
            nxt.cnt = cur.cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q         <= '0;
            ptr_q        <= '0;
            len_q        <= CNT_W'(DEF_LEN);
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= en && last;
            if (en) begin
                ch_q[ptr_q] <= nxt;
                if (last) begin
                    ptr_q <= '0;
                    // Length only changes on frame boundaries so every
                    // channel in a frame is filtered with the same L.
                    len_q <= len;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            y[k] = ch_q[k].level;
        end
    end

    assign ptr        = ptr_q;
    assign frame_done = frame_done_q;

`ifdef FILT_SCAN_EVT_EN
    logic [N_CH-1:0] set_pend;

    always_comb begin
        set_pend = '0;
        if (en && (nxt.level != cur.level)) begin
            set_pend[ptr_q] = 1'b1;
        end
    end

    filt_scan_evt_arb #(
        .N_CH (N_CH)
    ) u_evt_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_pend_i  (set_pend),
        .level_i     (y),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_ch_o    (evt_ch),
        .evt_level_o (evt_level)
    );
`endif

endmodule

// File: tb/tb_filt_scan.sv
// Self-checking bench for filt_scan: directed scenarios with hand-computed
// expectations, then randomized stimulus, all checked every cycle against a
// behavioural model of the filter/event rules. Event checks need FILT_SCAN_EVT_EN.
module tb_filt_scan;

    localparam int NCH = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] len;
    logic [NCH-1:0] i;
    logic [NCH-1:0] y;
    logic [2:0] ptr;
    logic       frame_done;
`ifdef FILT_SCAN_EVT_EN
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_ch;
    logic       evt_level;
`endif

    filt_scan #(
        .N_CH    (NCH),
        .CNT_W   (3),
        .DEF_LEN (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .len        (len),
        .i          (i),
        .y          (y),
        .ptr        (ptr),
        .frame_done (frame_done)
`ifdef FILT_SCAN_EVT_EN
        ,
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ch     (evt_ch),
        .evt_level  (evt_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cy    = 0;

    // Behavioural model: filtered levels, length of the current run of
    // disagreeing visits per channel, scan position, active length.
    bit [NCH-1:0] m_y;
    int           m_run [NCH];
    int           m_ptr;
    int           m_len;
    bit           m_fd;
`ifdef FILT_SCAN_EVT_EN
    bit [NCH-1:0] m_pend;
    bit           m_vld;
    int           m_ech;
    bit           m_elv;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cy, act, exp);
        end
    endtask

    task automatic model_step();
        int c;
        int eff_l;
        if (!rst_n) begin
            m_y   = '0;
            m_ptr = 0;
            m_len = 3;
            m_fd  = 1'b0;
            for (int k = 0; k < NCH; k++) m_run[k] = 0;
`ifdef FILT_SCAN_EVT_EN
            m_pend = '0;
            m_vld  = 1'b0;
            m_ech  = 0;
            m_elv  = 1'b0;
`endif
        end else begin
`ifdef FILT_SCAN_EVT_EN
            // Event queue uses the levels as they stood before this edge.
            if (!m_vld && m_pend != '0) begin
                int lo = 0;
                while (!m_pend[lo]) lo++;
                m_vld      = 1'b1;
                m_ech      = lo;
                m_elv      = m_y[lo];
                m_pend[lo] = 1'b0;
            end else if (m_vld && evt_ready) begin
                m_vld = 1'b0;
            end
`endif
            m_fd = en && (m_ptr == NCH - 1);
            if (en) begin
                c     = m_ptr;
                eff_l = (m_len == 0) ? 1 : m_len;
                if (i[c] == m_y[c]) begin
                    m_run[c] = 0;
                end else if (m_run[c] + 1 >= eff_l) begin
                    m_y[c]   = ~m_y[c];
                    m_run[c] = 0;
`ifdef FILT_SCAN_EVT_EN
                    m_pend[c] = 1'b1;
`endif
                end else begin
                    m_run[c] = m_run[c] + 1;
                end
                m_ptr = (m_ptr + 1) % NCH;
                if (m_ptr == 0) m_len = int'(len);
            end
        end
    endtask

    task automatic compare_all();
        chk("y", y, m_y);
        chk("ptr", ptr, m_ptr);
        chk("frame_done", frame_done, m_fd);
`ifdef FILT_SCAN_EVT_EN
        chk("evt_valid", evt_valid, m_vld);
        if (m_vld) begin
            chk("evt_ch", evt_ch, m_ech);
            chk("evt_level", evt_level, m_elv);
        end
`endif
    endtask

    // One clock: model advances on the rising edge, outputs are compared at
    // the following falling edge, where the caller then drives new inputs.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cy++;
        compare_all();
    endtask

    task automatic run_to(input int k);
        while (cy < k) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        len   = 3'd3;
        i     = '0;
`ifdef FILT_SCAN_EVT_EN
        evt_ready = 1'b0;
`endif
        @(negedge clk);
        repeat (3) cyc();
        chk("rst_y", y, 0);
        chk("rst_ptr", ptr, 0);
        chk("rst_frame_done", frame_done, 0);
`ifdef FILT_SCAN_EVT_EN
        chk("rst_evt_valid", evt_valid, 0);
`endif

        // Step filter, L=3: ch2 visited at cycles 2, 10, 18.
        rst_n = 1'b1;
        cy    = 0;
        i[2]  = 1'b1;
        chk("step_ptr0", ptr, 0);
        run_to(8);
        chk("first_frame_done", frame_done, 1);
        run_to(18);
        chk("step_y2_before", y[2], 0);
        run_to(19);
        chk("step_y_after", y, 8'h04);
`ifdef FILT_SCAN_EVT_EN
        run_to(20);
        chk("step_evt_valid", evt_valid, 1);
        chk("step_evt_ch", evt_ch, 2);
        chk("step_evt_level", evt_level, 1);
        evt_ready = 1'b1;
        run_to(21);
        chk("step_evt_taken", evt_valid, 0);
        evt_ready = 1'b0;
`endif

        // Backpressure: ch0 flips at end of 40, ch3 at end of 43.
        run_to(21);
        i[0] = 1'b1;
        i[3] = 1'b1;
        run_to(40);
        chk("bp_y0_before", y[0], 0);
        run_to(41);
        chk("bp_y0_after", y[0], 1);
        run_to(50);
        chk("bp_y", y, 8'h0D);
`ifdef FILT_SCAN_EVT_EN
        chk("bp_hold_valid", evt_valid, 1);
        chk("bp_hold_ch0", evt_ch, 0);
        evt_ready = 1'b1;
        run_to(51);
        chk("bp_bubble", evt_valid, 0);
        run_to(52);
        chk("bp_second_valid", evt_valid, 1);
        chk("bp_second_ch3", evt_ch, 3);
        chk("bp_second_level", evt_level, 1);
        run_to(53);
        chk("bp_drained", evt_valid, 0);
        evt_ready = 1'b0;
`endif

        // Glitch: ch1 differs only on visits 57 and 65.
        run_to(53);
        i[1] = 1'b1;
        run_to(66);
        i[1] = 1'b0;
        run_to(74);
        chk("glitch_y1", y[1], 0);
`ifdef FILT_SCAN_EVT_EN
        chk("glitch_no_evt", evt_valid, 0);
`endif
        // Run counter must have restarted: three fresh visits needed (81, 89, 97).
        i[1] = 1'b1;
        run_to(97);
        chk("glitch_rearm_y1_before", y[1], 0);
        run_to(98);
        chk("glitch_rearm_y1_after", y[1], 1);
`ifdef FILT_SCAN_EVT_EN
        evt_ready = 1'b1;
`endif

        // Length 3 -> 1 requested while ptr=1; old length holds to frame end.
        run_to(105);
        chk("len_ptr1", ptr, 1);
        len  = 3'd1;
        i[5] = 1'b1;
        run_to(110);
        chk("len_old_y5", y[5], 0);
        run_to(112);
        chk("len_frame_done", frame_done, 1);
        i[6] = 1'b1;
        run_to(118);
        chk("len_y6_before", y[6], 0);
        chk("len_y5_flipped", y[5], 1);
        run_to(119);
        chk("len_y6_first_visit", y[6], 1);
        len = 3'd0;
        run_to(120);
        i[7] = 1'b1;
        run_to(127);
        chk("len0_y7_before", y[7], 0);
        run_to(128);
        chk("len0_y7_after", y[7], 1);

        // Enable low for 5 cycles with the ch7 event pending.
`ifdef FILT_SCAN_EVT_EN
        evt_ready = 1'b0;
`endif
        run_to(129);
        en = 1'b0;
        chk("en_ptr", ptr, 1);
`ifdef FILT_SCAN_EVT_EN
        chk("en_evt_valid", evt_valid, 1);
        chk("en_evt_ch7", evt_ch, 7);
        run_to(130);
        evt_ready = 1'b1;
        run_to(131);
        chk("en_evt_accepted", evt_valid, 0);
`endif
        run_to(130);
        i[0] = 1'b0;
        run_to(134);
        chk("en_ptr_frozen", ptr, 1);
        chk("en_y_frozen", y, 8'hEF);
        en = 1'b1;

        // Reset with pend nonzero while ptr=2.
`ifdef FILT_SCAN_EVT_EN
        evt_ready = 1'b0;
`endif
        i[1] = 1'b0;
        i[2] = 1'b0;
        run_to(143);
        chk("rst_mid_ptr2", ptr, 2);
        rst_n = 1'b0;
        len   = 3'd1;
        run_to(144);
        chk("rst_mid_ptr", ptr, 0);
        chk("rst_mid_y", y, 0);
        chk("rst_mid_frame_done", frame_done, 0);
`ifdef FILT_SCAN_EVT_EN
        chk("rst_mid_evt_valid", evt_valid, 0);
`endif
        // len_q back to 3: one differing visit of ch0 must not flip it.
        rst_n = 1'b1;
        cy    = 0;
        i     = 8'h01;
        run_to(1);
        chk("rst_len_default", y[0], 0);
`ifdef FILT_SCAN_EVT_EN
        chk("rst_pend_dropped", evt_valid, 0);
`endif

        // Randomized phase, model-checked every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 799) != 0);
            en    = ($urandom_range(0, 7) != 0);
`ifdef FILT_SCAN_EVT_EN
            evt_ready = ($urandom_range(0, 2) != 0);
`endif
            if ($urandom_range(0, 39) == 0) len = 3'($urandom_range(0, 7));
            for (int b = 0; b < NCH; b++) begin
                if ($urandom_range(0, 11) == 0) i[b] = ~i[b];
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
